// File: rtl/matrix_rd_arbiter.sv
// matrix_rd_arbiter: round-robin burst arbiter for the matrix memory read port.
// Ports: clk/rst (sync, active-high); req + req_slot/req_row/req_col per requester;
// gnt one-hot registered grant; rd_data/rd_valid return word routed to its issuer;
// busy while granted, turning over or a read is in flight; mem_rd_slot/row/col
// registered memory address, mem_rd_data word valid the cycle after the address.
// Optional ARB_BURST_LIMIT_EN: preempt an owner after MAX_BURST reads when others wait.
module matrix_rd_arbiter #(
    parameter int N_REQ     = 3,
    parameter int MAX_BURST = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [2*N_REQ-1:0] req_slot,
    input  logic [3*N_REQ-1:0] req_row,
    input  logic [3*N_REQ-1:0] req_col,
    output logic [N_REQ-1:0]   gnt,
    output logic [15:0]        rd_data,
    output logic [N_REQ-1:0]   rd_valid,
    output logic               busy,
    output logic [1:0]         mem_rd_slot,
    output logic [2:0]         mem_rd_row,
    output logic [2:0]         mem_rd_col,
    input  logic [15:0]        mem_rd_data
);
    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;
    localparam int IW = $clog2(N_REQ);
    state_t state_q, state_d;
    logic [IW-1:0] last_q, last_d, owner_q, owner_d, tag_q, win, sel;
    logic win_vld, rel, issue, preempt, infl_q;
    logic [N_REQ-1:0] gnt_q, gnt_d, rd_valid_q;
    logic [15:0] rd_data_q;
    logic [1:0] slot_q;
    logic [2:0] row_q, col_q;

    if (N_REQ < 2 || MAX_BURST < 1) begin : g_param_chk
        $error("matrix_rd_arbiter: need N_REQ >= 2 and MAX_BURST >= 1");
    end

    // Scan downward so the requester nearest to last_q+1 is the final (winning) assignment.
    always_comb begin
        win = '0;
        win_vld = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (req[(int'(last_q) + k) % N_REQ]) begin
                win = IW'((int'(last_q) + k) % N_REQ);
                win_vld = 1'b1;
            end
        end
    end

`ifdef ARB_BURST_LIMIT_EN
    localparam int CW = $clog2(MAX_BURST + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // The grant cycle counts as the first read; the count saturates at MAX_BURST.
    assign preempt = cnt_q == CW'(MAX_BURST) && |(req & ~(N_REQ'(1) << owner_q));
    assign cnt_d = state_q == IDLE ? CW'(1) :
                   (issue && cnt_q != CW'(MAX_BURST)) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign preempt = 1'b0;
`endif

    assign rel = state_q == OWN && (!req[owner_q] || preempt);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? (win_vld ? OWN : IDLE) :
                  state_q == OWN  ? (rel ? TURN : OWN) : IDLE;
    end

    always_comb begin
        issue   = (state_q == IDLE && win_vld) || (state_q == OWN && !rel);
        sel     = state_q == IDLE ? win : owner_q;
        owner_d = issue ? sel : owner_q;
        last_d  = rel ? owner_q : last_q;
        gnt_d   = issue ? N_REQ'(1) << sel : '0;
    end

    // Read pipeline: the issuing owner rides along as a tag so the returned word
    // is strobed to the right requester even after the grant has moved on.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= IW'(N_REQ - 1);
            owner_q    <= '0;
            gnt_q      <= '0;
            infl_q     <= 1'b0;
            tag_q      <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            slot_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
        end else begin
            last_q     <= last_d;
            owner_q    <= owner_d;
            gnt_q      <= gnt_d;
            infl_q     <= issue;
            rd_valid_q <= infl_q ? N_REQ'(1) << tag_q : '0;
            if (issue) begin
                tag_q  <= sel;
                slot_q <= req_slot[2*int'(sel) +: 2];
                row_q  <= req_row[3*int'(sel) +: 3];
                col_q  <= req_col[3*int'(sel) +: 3];
            end
            if (infl_q) rd_data_q <= mem_rd_data;
        end
    end

    assign gnt         = gnt_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign busy        = state_q != IDLE || infl_q;
    assign mem_rd_slot = slot_q;
    assign mem_rd_row  = row_q;
    assign mem_rd_col  = col_q;
endmodule

// File: tb/tb_matrix_rd_arbiter.sv
// tb_matrix_rd_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_matrix_rd_arbiter;
    localparam int N  = 3;
    localparam int MB = 4;
`ifdef ARB_BURST_LIMIT_EN
    localparam int EXP_FIRST = MB;
`else
    localparam int EXP_FIRST = 10;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] req, gnt, rd_valid;
    logic [2*N-1:0] req_slot;
    logic [3*N-1:0] req_row, req_col;
    logic [15:0] rd_data, mem_rd_data;
    logic busy;
    logic [1:0] mem_rd_slot;
    logic [2:0] mem_rd_row, mem_rd_col;
    logic [15:0] mem [256];

    always #5 clk = ~clk;
    assign mem_rd_data = mem[{mem_rd_slot, mem_rd_row, mem_rd_col}];

    matrix_rd_arbiter #(.N_REQ(N), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .req_slot(req_slot), .req_row(req_row),
        .req_col(req_col), .gnt(gnt), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .mem_rd_slot(mem_rd_slot), .mem_rd_row(mem_rd_row),
        .mem_rd_col(mem_rd_col), .mem_rd_data(mem_rd_data)
    );

    // Model: who owns the port (-1 none), a one-cycle gap after a release,
    // and the single pending read (who, expected word).
    int m_owner, m_last, m_cnt, m_pwho;
    bit m_gap, m_pend;
    logic [15:0] m_pdata;
    logic [N-1:0] e_gnt, e_vld, pg;
    logic [15:0] e_data;
    logic [7:0] e_addr;
    logic e_busy;
    int rem[N], vcnt[N], gcnt[N];
    int issued0, kern_n, ord, first0;
    bit kern, seen1;
    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] addr_of(input int i);
        return {req_slot[2*i +: 2], req_row[3*i +: 3], req_col[3*i +: 3]};
    endfunction

    task automatic clr();
        for (int i = 0; i < N; i++) begin vcnt[i] = 0; gcnt[i] = 0; end
        ord = 0; first0 = 0; seen1 = 0; kern_n = 0; issued0 = 0;
    endtask

    task automatic step(input bit r);
        int iw, gi;
        bit others, stay;
        rst = r;
        for (int i = 0; i < N; i++) begin
            req[i] = rem[i] > 0;
            req_slot[2*i +: 2] = 2'($urandom);
            req_row[3*i +: 3]  = 3'($urandom);
            req_col[3*i +: 3]  = 3'($urandom);
        end
        if (kern) begin
            req_slot[1:0] = 2'd0;
            req_row[2:0]  = 3'(issued0 / 3);
            req_col[2:0]  = 3'(issued0 % 3);
        end
        iw = -1;
        if (r) begin
            m_owner = -1; m_gap = 0; m_last = N - 1; m_cnt = 0; m_pend = 0;
            e_gnt = '0; e_vld = '0; e_data = '0; e_addr = '0; e_busy = 0;
            for (int i = 0; i < N; i++) rem[i] = 0;
        end else begin
            e_vld = m_pend ? N'(1) << m_pwho : '0;
            if (m_pend) e_data = m_pdata;
            if (m_gap) m_gap = 0;
            else if (m_owner < 0) begin
                for (int k = 1; k <= N && iw < 0; k++)
                    if (req[(m_last + k) % N]) iw = (m_last + k) % N;
                if (iw >= 0) begin m_owner = iw; m_cnt = 1; end
            end else begin
                others = |(req & ~(N'(1) << m_owner));
`ifdef ARB_BURST_LIMIT_EN
                stay = req[m_owner] && !(m_cnt >= MB && others);
`else
                stay = req[m_owner];
`endif
                if (stay) begin
                    iw = m_owner;
                    if (m_cnt < MB) m_cnt++;
                end else begin
                    m_last = m_owner; m_owner = -1; m_gap = 1;
                end
            end
            m_pend = iw >= 0;
            if (m_pend) begin
                e_addr = addr_of(iw);
                m_pdata = mem[e_addr];
                m_pwho = iw;
                rem[iw]--;
                if (iw == 0) issued0++;
            end
            e_gnt = m_owner >= 0 ? N'(1) << m_owner : '0;
            e_busy = m_owner >= 0 || m_gap || m_pend;
        end
        @(posedge clk);
        #1;
        chk("gnt", gnt, e_gnt);
        chk("rd_valid", rd_valid, e_vld);
        chk("rd_data", rd_data, e_data);
        chk("busy", busy, e_busy);
        chk("mem_addr", {mem_rd_slot, mem_rd_row, mem_rd_col}, e_addr);
        gi = 0;
        for (int i = 0; i < N; i++) begin
            if (rd_valid[i]) vcnt[i]++;
            if (gnt[i]) begin gcnt[i]++; gi = i; end
        end
        if (gnt != '0 && gnt != pg) ord = ord * 4 + gi + 1;
        pg = gnt;
        if (rd_valid[1]) seen1 = 1;
        if (rd_valid[0] && !seen1) first0++;
        if (kern && rd_valid[0]) begin
            chk("kern_data", rd_data, kern_n + 1);
            kern_n++;
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req = '0; req_slot = '0; req_row = '0; req_col = '0;
        pg = '0; kern = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) mem[r*8 + c] = 16'(r*3 + c + 1);
        @(negedge clk);

        // Single 9-read kernel burst from requester 0
        step(1); clr(); kern = 1; rem[0] = 9;
        repeat (14) step(0);
        kern = 0;
        chk("kern_strobes", kern_n, 9);
        chk("kern_gnt_cycles", gcnt[0], 9);

        // Contention: all three request 3 reads at once
        step(1); clr();
        for (int i = 0; i < N; i++) rem[i] = 3;
        repeat (20) step(0);
        chk("cont_order", ord, 1*16 + 2*4 + 3);
        for (int i = 0; i < N; i++) chk("cont_strobes", vcnt[i], 3);

        // Fairness: 1 owns, 0 and 2 queue up, 2 must follow 1
        step(1); clr(); rem[1] = 3;
        step(0); step(0);
        rem[0] = 2; rem[2] = 2;
        repeat (15) step(0);
        chk("rr_order", ord, 2*16 + 3*4 + 1);

        // Reset on the 4th read of a burst, then a fresh request from 2
        step(1); clr(); rem[0] = 8;
        repeat (4) step(0);
        step(1);
        chk("rst_strobes0", vcnt[0], 3);
        rem[2] = 2;
        repeat (6) step(0);
        chk("rst_strobes2", vcnt[2], 2);

        // Burst limit: 0 wants 10 reads, 1 starts waiting
        step(1); clr(); rem[0] = 10;
        step(0);
        rem[1] = 3;
        repeat (25) step(0);
        chk("limit_first", first0, EXP_FIRST);
        chk("limit_total0", vcnt[0], 10);
        chk("limit_total1", vcnt[1], 3);

        // Single-cycle request pulse
        step(1); clr(); rem[1] = 1;
        repeat (5) step(0);
        chk("pulse_gnt", gcnt[1], 1);
        chk("pulse_strobes", vcnt[1], 1);

        // Random traffic with occasional resets
        step(1);
        repeat (600) begin
            for (int i = 0; i < N; i++)
                if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 6);
            step($urandom_range(0, 99) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/matrix_rd_arbiter.md
# matrix_rd_arbiter

Round-robin arbiter sharing the single read port of the matrix memory among `N_REQ` requesters: the convolution engine, the display scanner and the matrix ALU. A requester holds the port for a burst of back-to-back reads while its request stays high. The arbiter registers the memory address, tags each issued read with its owner and routes the returned word to that owner with a per-requester valid strobe. It sits between the requester blocks and the matrix memory.

## Interface
Parameters:
- `N_REQ`, default 3: number of requesters. Index 0 is the conv engine, 1 the display, 2 the ALU.
- `MAX_BURST`, default 16: maximum reads per grant when the burst limit is compiled in (see Configuration).

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `req` input `N_REQ`: per-requester request. Level-held for the whole burst.
- `req_slot` input 2*`N_REQ`: requester i's slot is bits [2i+1:2i].
- `req_row` input 3*`N_REQ`: requester i's row is bits [3i+2:3i].
- `req_col` input 3*`N_REQ`: requester i's col is bits [3i+2:3i].
- `gnt` output `N_REQ`: one-hot grant, registered.
- `rd_data` output 16: returned word, registered, shared by all requesters.
- `rd_valid` output `N_REQ`: one-hot strobe. `rd_data` belongs to requester i in this cycle.
- `busy` output 1: high while any grant is held or a read is in flight.
- `mem_rd_slot` output 2, `mem_rd_row` output 3, `mem_rd_col` output 3: registered memory address.
- `mem_rd_data` input 16: memory data. Valid the cycle after `mem_rd_*` is updated.

## Operation
- Reset values:
  - `gnt`, `rd_valid`, `rd_data`, `mem_rd_*` and `busy` all 0.
  - State is IDLE.
  - Round-robin pointer `last` = `N_REQ`-1, so requester 0 wins the first arbitration.
- States: IDLE, OWN, TURN.
- IDLE:
  - If any `req` bit is high, pick the winner w by searching upward from `last`+1 (mod `N_REQ`).
  - Set `gnt[w]`, set `owner`=w, load `mem_rd_*` from w's address, issue a read, go to OWN.
  - If no `req` bit is high, stay in IDLE.
- OWN, each cycle:
  - If `req[owner]`=1: load `mem_rd_*` from the owner's current address and issue a read.
  - If `req[owner]`=0: clear `gnt`, set `last`=`owner`, go to TURN. No read is issued.
- TURN: lasts exactly one cycle with no grant, so the last in-flight word can return. Then go to IDLE.
- Read pipeline:
  - Each issue latches the issuing owner into an in-flight tag.
  - On the next edge, `rd_data` <= `mem_rd_data` and `rd_valid[tag]` <= 1.
  - Exactly one `rd_valid` strobe is produced per issued read.
- The address inputs of non-owners are ignored. Requesters may change their address every cycle.
- Simultaneous events:
  - A release and another requester's assertion in the same cycle give TURN, then IDLE, then grant. The gap is 2 cycles with no grant.
  - The owner re-asserting in TURN is treated as a new request and arbitrated normally in IDLE.
- Reset asserted mid-burst clears everything on that edge. A read that was in flight produces no `rd_valid`.
- `busy` = (state != IDLE) OR (a read is in flight).

## Timing
- `req` seen at edge E0 while in IDLE gives `gnt` high and the first address on `mem_rd_*` after E0.
- The word for that address appears on `rd_data` with `rd_valid` after E1.
- Steady burst: one read per cycle, one `rd_valid` per cycle, 2-cycle address-to-data latency measured from `req`/address sampling.
- After release the last `rd_valid` still arrives one cycle later, during TURN.
- Worst-case wait for a requester with burst limit on: (`N_REQ`-1)*(`MAX_BURST`+2) cycles.

## Configuration
- `ARB_BURST_LIMIT_EN` defined:
  - OWN counts issued reads.
  - After `MAX_BURST` issues, if any other `req` bit is high, the arbiter forces a release: `gnt` drops, `last`=`owner`, go to TURN, even though `req[owner]` is still high.
  - The preempted requester must wait for `gnt` again. It sees `gnt` low and must not expect more data than it received `rd_valid` strobes.
  - With no competitor the count saturates and the burst continues.
- `ARB_BURST_LIMIT_EN` undefined: no counter. The owner keeps the port until it drops `req`. `MAX_BURST` is unused.

## Test plan
- Single burst: requester 0 requests the 9 kernel addresses (slot 0, rows 0-2, cols 0-2) with preloaded values 1..9 -> `gnt`=3'b001 after 1 cycle, 9 consecutive `rd_valid[0]` strobes carrying 1..9 in order, then TURN, then `busy` falls.
- Contention: `req`=3'b111 asserted together, each held for 3 reads -> grant order 0, 1, 2, a 1-cycle TURN between owners, each requester receives exactly 3 strobes with data from its own addresses.
- Round-robin fairness: requester 1 releases while requesters 0 and 2 are waiting -> requester 2 is granted before requester 0.
- Reset mid-burst: `rst` asserted on the 4th read of a burst -> on the next cycle `gnt`, `rd_valid` and `busy` are 0, no stray strobe appears, and a new `req[2]` is granted first-arbitration style.
- Burst limit (with `ARB_BURST_LIMIT_EN`, `MAX_BURST`=4): requester 0 holds `req` for 10 reads while requester 1 waits -> requester 0 gets 4 strobes, then requester 1 is granted, then requester 0 resumes after requester 1 releases. Without the macro, requester 0 gets all 10 strobes first.
- Single-cycle request: `req[1]` pulsed for one cycle -> one grant cycle, exactly one read, one `rd_valid[1]`.
